// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32 core: sequences fetch, decode, execute,
// memory access and PC update. All strobes are decoded combinationally from state.
module multicycle_control #(
    parameter logic [4:0] ALU_ADD = 5'b00000,
    parameter int         STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               invalid_inst,
    input  logic               ialign,
    input  logic               mem_fc,
    input  logic               mem_malign,
    input  logic               opcode_load,
    input  logic               opcode_miscmem,
    input  logic               opcode_opimm,
    input  logic               opcode_auipc,
    input  logic               opcode_store,
    input  logic               opcode_op,
    input  logic               opcode_lui,
    input  logic               opcode_branch,
    input  logic               opcode_jalr,
    input  logic               opcode_jal,
    input  logic               opcode_system,
    input  logic [4:0]         aluop_in,
    input  logic               alu_cond,
    output logic               write_pc,
    output logic               write_ir,
    output logic               write_rd,
    output logic               mem_read,
    output logic               mem_write,
    output logic [4:0]         alu_op,
    output logic               addr_sel,
    output logic               rd_sel,
    output logic [1:0]         alu_insel1,
    output logic [1:0]         alu_insel2,
    output logic               trap,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [STATE_W-1:0] S_FETCH  = 'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 'd1;
    localparam logic [STATE_W-1:0] S_ALU    = 'd2;
    localparam logic [STATE_W-1:0] S_MEM    = 'd3;
    localparam logic [STATE_W-1:0] S_BRANCH = 'd4;
    localparam logic [STATE_W-1:0] S_LINK   = 'd5;
    localparam logic [STATE_W-1:0] S_JUMP   = 'd6;
    localparam logic [STATE_W-1:0] S_PCINC  = 'd7;
    localparam logic [STATE_W-1:0] S_TRAP   = 'd8;

    logic [STATE_W-1:0] state, state_next;
    logic load_r, store_r, op_r, opimm_r, lui_r, auipc_r, jalr_r;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            load_r  <= 1'b0;
            store_r <= 1'b0;
            op_r    <= 1'b0;
            opimm_r <= 1'b0;
            lui_r   <= 1'b0;
            auipc_r <= 1'b0;
            jalr_r  <= 1'b0;
        end else begin
            state <= state_next;
            // The IR may change after DECODE, so later states use these copies.
            if (state == S_DECODE) begin
                load_r  <= opcode_load;
                store_r <= opcode_store;
                op_r    <= opcode_op;
                opimm_r <= opcode_opimm;
                lui_r   <= opcode_lui;
                auipc_r <= opcode_auipc;
                jalr_r  <= opcode_jalr;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (ialign)      state_next = S_TRAP;
                else if (mem_fc) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (invalid_inst)                       state_next = S_TRAP;
                else if (opcode_system)                 state_next = S_TRAP;
                else if (opcode_load || opcode_store)   state_next = S_MEM;
                else if (opcode_branch)                 state_next = S_BRANCH;
                else if (opcode_jal || opcode_jalr)     state_next = S_LINK;
                else if (opcode_miscmem)                state_next = S_PCINC;
                else if (opcode_op || opcode_opimm || opcode_lui || opcode_auipc)
                                                        state_next = S_ALU;
                else                                    state_next = S_TRAP;
            end
            S_ALU:    state_next = S_PCINC;
            S_MEM: begin
                if (mem_malign)  state_next = S_TRAP;
                else if (mem_fc) state_next = S_PCINC;
            end
            S_BRANCH: state_next = alu_cond ? S_JUMP : S_PCINC;
            S_LINK:   state_next = S_JUMP;
            S_JUMP:   state_next = S_FETCH;
            S_PCINC:  state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    always_comb begin
        write_pc   = 1'b0;
        write_ir   = 1'b0;
        write_rd   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = ALU_ADD;
        addr_sel   = 1'b0;
        rd_sel     = 1'b0;
        alu_insel1 = 2'b00;
        alu_insel2 = 2'b00;
        trap       = 1'b0;
        // Outputs fall to defaults immediately on reset, without waiting for a clock.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    if (!ialign) begin
                        mem_read = 1'b1;
                        write_ir = mem_fc;
                    end
                end
                S_ALU: begin
                    write_rd = 1'b1;
                    if (op_r) begin
                        alu_op = aluop_in;
                    end else if (opimm_r) begin
                        alu_insel2 = 2'b01;
                        alu_op     = aluop_in;
                    end else if (lui_r) begin
                        alu_insel1 = 2'b10;
                        alu_insel2 = 2'b01;
                    end else if (auipc_r) begin
                        alu_insel1 = 2'b01;
                        alu_insel2 = 2'b01;
                    end
                end
                S_MEM: begin
                    alu_insel2 = 2'b01;
                    addr_sel   = 1'b1;
                    if (!mem_malign) begin
                        mem_read  = load_r;
                        mem_write = store_r;
                        if (mem_fc && load_r) begin
                            write_rd = 1'b1;
                            rd_sel   = 1'b1;
                        end
                    end
                end
                S_BRANCH: alu_op = aluop_in;
                S_LINK: begin
                    alu_insel1 = 2'b01;
                    alu_insel2 = 2'b10;
                    write_rd   = 1'b1;
                end
                S_JUMP: begin
                    alu_insel1 = jalr_r ? 2'b00 : 2'b01;
                    alu_insel2 = 2'b01;
                    write_pc   = 1'b1;
                end
                S_PCINC: begin
                    alu_insel1 = 2'b01;
                    alu_insel2 = 2'b10;
                    write_pc   = 1'b1;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALU_ADD, default 5'b00000, alu_op code for addition.
REQ-002 SHALL have parameter STATE_W, default 4, width of state register.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports invalid_inst, ialign, mem_fc, mem_malign  input  1 each: illegal IR, misaligned PC, memory transfer complete, misaligned data address.
REQ-006 SHALL have ports opcode_load, opcode_miscmem, opcode_opimm, opcode_auipc, opcode_store, opcode_op, opcode_lui, opcode_branch, opcode_jalr, opcode_jal, opcode_system  input  1 each: one-hot decode of IR.
REQ-007 SHALL have port aluop_in  input  5  ALU operation decoded from IR funct fields.
REQ-008 SHALL have port alu_cond  input  1  ALU compare result, 1 = branch taken.
REQ-009 SHALL have ports write_pc, write_ir, write_rd, mem_read, mem_write  output  1 each: register and memory strobes.
REQ-010 SHALL have port alu_op  output  5  ALU operation.
REQ-011 SHALL have ports addr_sel (0=PC, 1=ALU result) and rd_sel (0=ALU result, 1=memory data)  output  1 each.
REQ-012 SHALL have ports alu_insel1 (00=operand A, 01=PC, 10=zero) and alu_insel2 (00=operand B, 01=immediate, 10=constant 4)  output  2 each.
REQ-013 SHALL have port trap  output  1  high while in TRAP state.

Function
REQ-014 SHALL be a Moore/Mealy FSM with states FETCH, DECODE, ALU, MEM, BRANCH, LINK, JUMP, PCINC, TRAP; all outputs combinational from state, registered opcode flags and inputs.
REQ-015 SHALL default every output in every state to 0, except alu_op=ALU_ADD; states below list only deviations.
REQ-016 FETCH: if ialign -> TRAP, no strobes; else addr_sel=0, mem_read=1; on mem_fc write_ir=1 and -> DECODE; else stay.
REQ-017 DECODE: no strobes (datapath latches operands A/B unconditionally); next state by priority invalid_inst -> TRAP, opcode_system -> TRAP, load|store -> MEM, branch -> BRANCH, jal|jalr -> LINK, miscmem -> PCINC, op|opimm|lui|auipc -> ALU; no opcode flag set -> TRAP.
REQ-018 ALU: write_rd=1, rd_sel=0; op: insel 00/00, alu_op=aluop_in; opimm: 00/01, aluop_in; lui: 10/01, ADD; auipc: 01/01, ADD; -> PCINC.
REQ-019 MEM: insel 00/01, ADD, addr_sel=1; if mem_malign -> TRAP with mem_read=mem_write=0 that cycle; else mem_read=load, mem_write=store; on mem_fc: load sets write_rd=1, rd_sel=1; -> PCINC; else stay, outputs held.
REQ-020 BRANCH: insel 00/00, alu_op=aluop_in; sample alu_cond: 1 -> JUMP, 0 -> PCINC.
REQ-021 LINK: insel 01/10, ADD, write_rd=1, rd_sel=0 -> JUMP.
REQ-022 JUMP: insel1=00 if jalr else 01, insel2=01, ADD, write_pc=1 -> FETCH.
REQ-023 PCINC: insel 01/10, ADD, write_pc=1 -> FETCH.
REQ-024 TRAP: trap=1, all strobes 0; stays until reset; inputs ignored.
REQ-025 SHALL hold every strobe at most one cycle per state visit except mem_read/mem_write, held until mem_fc or trap.
REQ-026 Zero-wait latency: op/opimm/lui/auipc 4 cycles, taken branch/jal/jalr 4, not-taken branch 4, load/store 4, fence 3.
REQ-027 mem_fc outside FETCH/MEM SHALL be ignored.

Reset
REQ-028 rst_n low SHALL force state FETCH and all outputs to defaults asynchronously, including mid-memory-access and from TRAP.
REQ-029 First rising clk after rst_n deasserts SHALL evaluate FETCH.

Verification
REQ-030 addi, mem_fc=1 in fetch -> FETCH(mem_read,write_ir) DECODE ALU(write_rd,insel 00/01,alu_op=aluop_in) PCINC(write_pc,insel 01/10); back to FETCH on cycle 5.
REQ-031 lw, mem_fc low 3 cycles in MEM -> mem_read,addr_sel=1 held 4 cycles, write_rd with rd_sel=1 only on 4th, then PCINC.
REQ-032 beq with alu_cond=1 -> BRANCH then JUMP (insel1=01, write_pc); alu_cond=0 -> PCINC.
REQ-033 jalr -> LINK(write_rd, insel 01/10) then JUMP(insel1=00, insel2=01, write_pc).
REQ-034 invalid_inst in DECODE, or mem_malign in MEM, or ialign in FETCH -> TRAP next cycle, trap=1, no strobes for 10 cycles; rst_n pulse -> FETCH.
REQ-035 rst_n asserted while MEM waits on mem_fc -> mem_write drops without clock edge; restarts in FETCH.
